// File: rtl/trdb_pkg.sv
// Shared widths and comparator mode encoding for the trace encoder debug blocks.
package trdb_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned CAUSE_LEN = 5;
    localparam int unsigned PRIV_LEN  = 2;

    typedef enum logic {
        MODE_RANGE = 1'b0,
        MODE_MATCH = 1'b1
    } trdb_mode_e;

    // Inclusive unsigned range test; an inverted range (lower > upper) never passes.
    function automatic logic in_range(input logic [XLEN-1:0] lower,
                                      input logic [XLEN-1:0] upper,
                                      input logic [XLEN-1:0] value);
        return (value >= lower) && (value <= upper);
    endfunction

endpackage

// File: rtl/trdb_range_match.sv
// One qualification comparator: disabled, exact match, or inclusive range.
module trdb_range_match
    import trdb_pkg::*;
#(
    parameter int unsigned W = XLEN
) (
    input  logic         filter_en_i,
    input  logic         mode_i,
    input  logic [W-1:0] lower_i,
    input  logic [W-1:0] upper_i,
    input  logic [W-1:0] match_i,
    input  logic [W-1:0] value_i,
    output logic         ok_o
);

    logic [XLEN-1:0] lower_ext;
    logic [XLEN-1:0] upper_ext;
    logic [XLEN-1:0] value_ext;

    assign lower_ext = XLEN'(lower_i);
    assign upper_ext = XLEN'(upper_i);
    assign value_ext = XLEN'(value_i);

    always_comb begin
        ok_o = 1'b1;
        if (filter_en_i) begin
            if (mode_i == MODE_MATCH) begin
                ok_o = (value_i == match_i);
            end else begin
                ok_o = in_range(lower_ext, upper_ext, value_ext);
            end
        end
    end

endmodule

// File: rtl/trdb_filter.sv
// Trace qualification filter: global enable ANDed with five field comparators.
module trdb_filter
    import trdb_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 trace_enable_i,

    input  logic                 cause_filter_i,
    input  logic [CAUSE_LEN-1:0] upper_cause_i,
    input  logic [CAUSE_LEN-1:0] lower_cause_i,
    input  logic [CAUSE_LEN-1:0] match_cause_i,
    input  logic                 cause_mode_i,
    input  logic [CAUSE_LEN-1:0] cause_i,

    input  logic                 tvec_filter_i,
    input  logic [XLEN-1:2]      upper_tvec_i,
    input  logic [XLEN-1:2]      lower_tvec_i,
    input  logic [XLEN-1:2]      match_tvec_i,
    input  logic                 tvec_mode_i,
    input  logic [XLEN-1:2]      tvec_i,

    input  logic                 tval_filter_i,
    input  logic [XLEN-1:0]      upper_tval_i,
    input  logic [XLEN-1:0]      lower_tval_i,
    input  logic [XLEN-1:0]      match_tval_i,
    input  logic                 tval_mode_i,
    input  logic [XLEN-1:0]      tval_i,

    input  logic                 priv_lvl_filter_i,
    input  logic [PRIV_LEN-1:0]  upper_priv_lvl_i,
    input  logic [PRIV_LEN-1:0]  lower_priv_lvl_i,
    input  logic [PRIV_LEN-1:0]  match_priv_lvl_i,
    input  logic                 priv_lvl_mode_i,
    input  logic [PRIV_LEN-1:0]  priv_lvl_i,

    input  logic                 iaddr_filter_i,
    input  logic [XLEN-1:0]      upper_iaddr_i,
    input  logic [XLEN-1:0]      lower_iaddr_i,
    input  logic [XLEN-1:0]      match_iaddr_i,
    input  logic                 iaddr_mode_i,
    input  logic [XLEN-1:0]      iaddr_i,

    output logic                 nc_qualified_o
);

    logic ok_cause, ok_tvec, ok_tval, ok_priv_lvl, ok_iaddr;

    // Stateless block: clock and reset are present only for interface uniformity.
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_ni;

    trdb_range_match #(.W(CAUSE_LEN)) u_cause (
        .filter_en_i(cause_filter_i), .mode_i(cause_mode_i),
        .lower_i(lower_cause_i), .upper_i(upper_cause_i),
        .match_i(match_cause_i), .value_i(cause_i), .ok_o(ok_cause)
    );

    trdb_range_match #(.W(XLEN-2)) u_tvec (
        .filter_en_i(tvec_filter_i), .mode_i(tvec_mode_i),
        .lower_i(lower_tvec_i), .upper_i(upper_tvec_i),
        .match_i(match_tvec_i), .value_i(tvec_i), .ok_o(ok_tvec)
    );

    trdb_range_match #(.W(XLEN)) u_tval (
        .filter_en_i(tval_filter_i), .mode_i(tval_mode_i),
        .lower_i(lower_tval_i), .upper_i(upper_tval_i),
        .match_i(match_tval_i), .value_i(tval_i), .ok_o(ok_tval)
    );

    trdb_range_match #(.W(PRIV_LEN)) u_priv_lvl (
        .filter_en_i(priv_lvl_filter_i), .mode_i(priv_lvl_mode_i),
        .lower_i(lower_priv_lvl_i), .upper_i(upper_priv_lvl_i),
        .match_i(match_priv_lvl_i), .value_i(priv_lvl_i), .ok_o(ok_priv_lvl)
    );

    trdb_range_match #(.W(XLEN)) u_iaddr (
        .filter_en_i(iaddr_filter_i), .mode_i(iaddr_mode_i),
        .lower_i(lower_iaddr_i), .upper_i(upper_iaddr_i),
        .match_i(match_iaddr_i), .value_i(iaddr_i), .ok_o(ok_iaddr)
    );

    assign nc_qualified_o = trace_enable_i & ok_cause & ok_tvec & ok_tval
                          & ok_priv_lvl & ok_iaddr;

endmodule

// File: tb/tb_trdb_filter.sv
// Directed and randomized checks of the trace qualification filter.
module tb_trdb_filter;
    import trdb_pkg::*;

    logic clk = 1'b0;
    logic rst_ni;
    logic trace_enable;

    logic                 cause_filter, cause_mode;
    logic [CAUSE_LEN-1:0] upper_cause, lower_cause, match_cause, cause;
    logic                 tvec_filter, tvec_mode;
    logic [XLEN-1:2]      upper_tvec, lower_tvec, match_tvec, tvec;
    logic                 tval_filter, tval_mode;
    logic [XLEN-1:0]      upper_tval, lower_tval, match_tval, tval;
    logic                 priv_filter, priv_mode;
    logic [PRIV_LEN-1:0]  upper_priv, lower_priv, match_priv, priv;
    logic                 iaddr_filter, iaddr_mode;
    logic [XLEN-1:0]      upper_iaddr, lower_iaddr, match_iaddr, iaddr;
    logic                 qualified;

    int tests = 0;
    int fails = 0;
    bit    exp_q[$];
    string tag_q[$];

    always #5 clk = ~clk;

    trdb_filter dut (
        .clk_i(clk), .rst_ni(rst_ni), .trace_enable_i(trace_enable),
        .cause_filter_i(cause_filter), .upper_cause_i(upper_cause),
        .lower_cause_i(lower_cause), .match_cause_i(match_cause),
        .cause_mode_i(cause_mode), .cause_i(cause),
        .tvec_filter_i(tvec_filter), .upper_tvec_i(upper_tvec),
        .lower_tvec_i(lower_tvec), .match_tvec_i(match_tvec),
        .tvec_mode_i(tvec_mode), .tvec_i(tvec),
        .tval_filter_i(tval_filter), .upper_tval_i(upper_tval),
        .lower_tval_i(lower_tval), .match_tval_i(match_tval),
        .tval_mode_i(tval_mode), .tval_i(tval),
        .priv_lvl_filter_i(priv_filter), .upper_priv_lvl_i(upper_priv),
        .lower_priv_lvl_i(lower_priv), .match_priv_lvl_i(match_priv),
        .priv_lvl_mode_i(priv_mode), .priv_lvl_i(priv),
        .iaddr_filter_i(iaddr_filter), .upper_iaddr_i(upper_iaddr),
        .lower_iaddr_i(lower_iaddr), .match_iaddr_i(match_iaddr),
        .iaddr_mode_i(iaddr_mode), .iaddr_i(iaddr),
        .nc_qualified_o(qualified)
    );

    // Independent field model on zero-extended 32-bit operands.
    function automatic bit fld_ok(input bit en, input bit mode,
                                  input logic [31:0] lo, input logic [31:0] hi,
                                  input logic [31:0] m, input logic [31:0] v);
        if (!en) return 1'b1;
        if (mode) return v == m;
        if (lo > hi) return 1'b0;
        return !(v < lo) && !(v > hi);
    endfunction

    function automatic bit model();
        return trace_enable
            && fld_ok(cause_filter, cause_mode, 32'(lower_cause), 32'(upper_cause), 32'(match_cause), 32'(cause))
            && fld_ok(tvec_filter, tvec_mode, 32'(lower_tvec), 32'(upper_tvec), 32'(match_tvec), 32'(tvec))
            && fld_ok(tval_filter, tval_mode, lower_tval, upper_tval, match_tval, tval)
            && fld_ok(priv_filter, priv_mode, 32'(lower_priv), 32'(upper_priv), 32'(match_priv), 32'(priv))
            && fld_ok(iaddr_filter, iaddr_mode, lower_iaddr, upper_iaddr, match_iaddr, iaddr);
    endfunction

    // Push the expectation for the current inputs, then compare on the falling edge.
    task automatic check(input string tag, input bit exp);
        bit    e;
        string t;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        tests++;
        assert (qualified === e) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", t, qualified, e);
        end
    endtask

    task automatic all_off();
        cause_filter = 0; cause_mode = 0; upper_cause = '0; lower_cause = '0; match_cause = '0; cause = '0;
        tvec_filter  = 0; tvec_mode  = 0; upper_tvec  = '0; lower_tvec  = '0; match_tvec  = '0; tvec  = '0;
        tval_filter  = 0; tval_mode  = 0; upper_tval  = '0; lower_tval  = '0; match_tval  = '0; tval  = '0;
        priv_filter  = 0; priv_mode  = 0; upper_priv  = '0; lower_priv  = '0; match_priv  = '0; priv  = '0;
        iaddr_filter = 0; iaddr_mode = 0; upper_iaddr = '0; lower_iaddr = '0; match_iaddr = '0; iaddr = '0;
    endtask

    initial begin
        rst_ni = 1'b0;
        trace_enable = 1'b0;
        all_off();
        check("reset_te0", 1'b0);
        rst_ni = 1'b1;
        check("te0_all_off", 1'b0);
        trace_enable = 1'b1;
        check("te1_all_off", 1'b1);

        // iaddr range
        iaddr_filter = 1; iaddr_mode = 0; lower_iaddr = 32'h1000; upper_iaddr = 32'h1FFF;
        iaddr = 32'h1000; check("iaddr_lo_edge", 1'b1);
        iaddr = 32'h1FFF; check("iaddr_hi_edge", 1'b1);
        iaddr = 32'h2000; check("iaddr_above", 1'b0);
        iaddr = 32'h0FFF; check("iaddr_below", 1'b0);
        lower_iaddr = 32'h2000; upper_iaddr = 32'h1000;
        iaddr = 32'h1000; check("iaddr_empty_a", 1'b0);
        iaddr = 32'h1800; check("iaddr_empty_b", 1'b0);
        iaddr = 32'h2000; check("iaddr_empty_c", 1'b0);
        lower_iaddr = 32'h7FFF_FFFF; upper_iaddr = 32'hFFFF_FFFF;
        iaddr = 32'h8000_0000; check("iaddr_unsigned_hi", 1'b1);
        iaddr = 32'h0000_0001; check("iaddr_unsigned_lo", 1'b0);
        iaddr_mode = 1; match_iaddr = 32'h8000_0004;
        iaddr = 32'h8000_0004; check("iaddr_match_hit", 1'b1);
        iaddr = 32'h8000_0000; check("iaddr_match_miss", 1'b0);
        all_off();

        // cause match
        cause_filter = 1; cause_mode = 1; match_cause = 5'h02;
        cause = 5'd2; check("cause_match_hit", 1'b1);
        cause = 5'd3; check("cause_match_miss", 1'b0);
        cause_filter = 0;
        check("cause_disabled", 1'b1);
        all_off();

        // priv match plus tval range
        priv_filter = 1; priv_mode = 1; match_priv = 2'b11;
        tval_filter = 1; tval_mode = 0; lower_tval = 32'h0; upper_tval = 32'hFF;
        priv = 2'd3; tval = 32'h80;  check("priv3_tval80", 1'b1);
        priv = 2'd3; tval = 32'h100; check("priv3_tval100", 1'b0);
        priv = 2'd0; tval = 32'h80;  check("priv0_tval80", 1'b0);
        all_off();

        // tvec single-point range
        tvec_filter = 1; tvec_mode = 0; lower_tvec = 30'h40; upper_tvec = 30'h40;
        tvec = 30'h40; check("tvec_point_hit", 1'b1);
        tvec = 30'h41; check("tvec_point_above", 1'b0);
        tvec = 30'h3F; check("tvec_point_below", 1'b0);
        all_off();

        // all five enabled and passing, then break one at a time
        cause_filter = 1; cause_mode = 1; match_cause = 5'h02; cause = 5'h02;
        tvec_filter  = 1; tvec_mode  = 0; lower_tvec = 30'h40; upper_tvec = 30'h40; tvec = 30'h40;
        tval_filter  = 1; tval_mode  = 0; lower_tval = 32'h0; upper_tval = 32'hFF; tval = 32'h80;
        priv_filter  = 1; priv_mode  = 1; match_priv = 2'b11; priv = 2'b11;
        iaddr_filter = 1; iaddr_mode = 0; lower_iaddr = 32'h1000; upper_iaddr = 32'h1FFF; iaddr = 32'h1800;
        check("all_pass", 1'b1);
        cause = 5'h03;        check("all_bad_cause", 1'b0); cause = 5'h02;
        tvec  = 30'h41;       check("all_bad_tvec",  1'b0); tvec  = 30'h40;
        tval  = 32'h100;      check("all_bad_tval",  1'b0); tval  = 32'h80;
        priv  = 2'b01;        check("all_bad_priv",  1'b0); priv  = 2'b11;
        iaddr = 32'h2000;     check("all_bad_iaddr", 1'b0); iaddr = 32'h1800;
        check("all_restored", 1'b1);
        rst_ni = 1'b0;        check("all_in_reset", 1'b1);
        rst_ni = 1'b1;        check("all_after_reset", 1'b1);
        trace_enable = 1'b0;  check("all_te0", 1'b0);
        trace_enable = 1'b1;

        // randomized fields over small value pools so hits and misses both occur
        for (int i = 0; i < 60; i++) begin
            trace_enable = ($urandom_range(0, 7) != 0);
            cause_filter = 1'($urandom_range(0, 1)); cause_mode = 1'($urandom_range(0, 1));
            lower_cause = 5'($urandom_range(0, 7)); upper_cause = 5'($urandom_range(0, 7));
            match_cause = 5'($urandom_range(0, 7)); cause = 5'($urandom_range(0, 7));
            tvec_filter = 1'($urandom_range(0, 1)); tvec_mode = 1'($urandom_range(0, 1));
            lower_tvec = 30'($urandom_range(0, 7)); upper_tvec = 30'($urandom_range(0, 7));
            match_tvec = 30'($urandom_range(0, 7)); tvec = 30'($urandom_range(0, 7));
            tval_filter = 1'($urandom_range(0, 1)); tval_mode = 1'($urandom_range(0, 1));
            lower_tval = 32'($urandom_range(0, 7)) << 28; upper_tval = 32'($urandom_range(0, 7)) << 28;
            match_tval = 32'($urandom_range(0, 7)) << 28; tval = 32'($urandom_range(0, 7)) << 28;
            priv_filter = 1'($urandom_range(0, 1)); priv_mode = 1'($urandom_range(0, 1));
            lower_priv = 2'($urandom_range(0, 3)); upper_priv = 2'($urandom_range(0, 3));
            match_priv = 2'($urandom_range(0, 3)); priv = 2'($urandom_range(0, 3));
            iaddr_filter = 1'($urandom_range(0, 1)); iaddr_mode = 1'($urandom_range(0, 1));
            lower_iaddr = 32'($urandom_range(0, 7)) << 28; upper_iaddr = 32'($urandom_range(0, 7)) << 28;
            match_iaddr = 32'($urandom_range(0, 7)) << 28; iaddr = 32'($urandom_range(0, 7)) << 28;
            check($sformatf("rand_%0d", i), model());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/trdb_filter.md
# trdb_filter

Qualification filter of the RISC-V trace encoder. Every cycle it decides whether the currently retired instruction/trap is "qualified" for tracing. It combines a global trace enable with five independently configurable comparators: trap cause, trap vector, trap value, privilege level and instruction address. It sits between the trace ingress port and the packet emitter, whose trace-valid gating consumes `nc_qualified_o`.

## Interface
Parameters (from `trdb_pkg`, not module parameters):
- `XLEN`, 32, architectural address/data width
- `CAUSE_LEN`, 5, trap cause width
- `PRIV_LEN`, 2, privilege level width

Ports:
- `clk_i`  in  1  clock (one clock domain)
- `rst_ni`  in  1  asynchronous, active-low reset
- `trace_enable_i`  in  1  global enable
- For each field F, with widths W(cause)=CAUSE_LEN, W(tvec)=XLEN-2 (bits [XLEN-1:2]), W(tval)=XLEN, W(priv_lvl)=PRIV_LEN, W(iaddr)=XLEN:
  - `F_filter_i`  in  1  comparator enable
  - `upper_F_i`  in  W  inclusive range upper bound
  - `lower_F_i`  in  W  inclusive range lower bound
  - `match_F_i`  in  W  exact-match value
  - `F_mode_i`  in  1  0 = range mode, 1 = match mode
  - `F_i`  in  W  observed value
- `nc_qualified_o`  out  1  instruction qualified (combinational)

## Operation
- Per field F, the pass flag `ok_F` is:
  - 1 when `F_filter_i`=0 (comparator disabled, field is don't-care);
  - match mode: `F_i == match_F_i`;
  - range mode: `lower_F_i <= F_i && F_i <= upper_F_i`, unsigned, both bounds inclusive.
- Range with `lower > upper` is empty: `ok_F`=0 for every value.
- `nc_qualified_o = trace_enable_i & ok_cause & ok_tvec & ok_tval & ok_priv_lvl & ok_iaddr`.
- Comparators are always evaluated; there is no dependency on whether a trap occurred.
- All comparisons are zero-extended and exact-width; there is no sign handling.

## Timing
- `nc_qualified_o` is purely combinational from the inputs, with zero latency. It is valid in the same cycle as its inputs, before the next rising edge.
- The block holds no state; `clk_i`/`rst_ni` exist for interface uniformity.
- During reset (`rst_ni`=0) the output still follows the combinational equation. Consumers apply their own reset gating.
- Input changes propagate without a glitch requirement. The output is sampled only at the clock edge.

## Structure
- `XLEN`, `CAUSE_LEN`, `PRIV_LEN` live in `trdb_pkg`; the module imports the package.
- One natural sub-module is `trdb_range_match #(W)`, containing the `filter_en`/`mode`/`lower`/`upper`/`match`/`value` → `ok` logic. It is instantiated five times with the field width.
- The top level does the AND reduction only.

## Test plan
- `trace_enable_i`=0, all filters disabled → `nc_qualified_o`=0. Then `trace_enable_i`=1 with all filters disabled → 1.
- iaddr range, mode 0, lower=0x1000, upper=0x1FFF:
  - `iaddr_i`=0x1000 → 1, 0x1FFF → 1, 0x2000 → 0, 0x0FFF → 0.
  - lower=0x2000, upper=0x1000 → 0 for any address.
- cause match, mode 1, `match_cause_i`=5'h02: `cause_i`=2 → 1, `cause_i`=3 → 0. With `cause_filter_i`=0 and `cause_i`=3 → 1.
- priv_lvl match 2'b11 plus tval range [0x0,0xFF]:
  - priv=3, tval=0x80 → 1.
  - priv=3, tval=0x100 → 0.
  - priv=0, tval=0x80 → 0.
- tvec range on bits [31:2], lower=30'h0000_0040, upper=30'h0000_0040: `tvec_i`=30'h40 → 1, 30'h41 → 0.
- All five filters enabled and passing → 1. Then flip one field at a time to failing → 0 each time. Toggling `rst_ni` mid-sequence does not change the combinational result.
